neuron_bin_sched: RTL and testbench

//  Layer sequencer for one Neuron_bin datapath. Time-multiplexes the datapath over N_NEURONS output neurons.
//  For each neuron it streams IN_WORDS 8-bit activation/weight word pairs from synchronous RAM/ROMs,

---
 rtl/neuron_bin_sched_pkg.sv | 17 +
 rtl/neuron_bin_sched_packer.sv | 46 ++++
 rtl/neuron_bin_sched.sv | 190 +++++++++++++++++++
 tb/tb_neuron_bin_sched.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_bin_sched_pkg.sv
// Shared definitions for the Neuron_bin layer sequencer: FSM states and pipeline latencies.
package neuron_bin_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FEED    = 3'd1,
    S_DRAIN   = 3'd2,
    S_QUANT   = 3'd3,
    S_COLLECT = 3'd4,
    S_EMIT    = 3'd5,
    S_FIN     = 3'd6
  } sched_state_e;

  localparam int unsigned MEM_LAT = 1;
  localparam int unsigned NB_LAT  = 3;

endpackage

// File: rtl/neuron_bin_sched_packer.sv
// bit_packer8: collects neuron result bits into a byte and presents it on a valid/ready register.
module bit_packer8 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [2:0] idx_i,
  input  logic       bit_i,
  input  logic       flush_i,
  input  logic       ready_i,
  output logic [7:0] data_o,
  output logic       valid_o
);

  logic [7:0] pack_q, pack_d;
  logic [7:0] data_q;
  logic       valid_q;
  logic       hs;

  always_comb begin
    hs     = valid_q && ready_i;
    pack_d = pack_q;
    if (hs) pack_d = '0;
    if (push_i) pack_d[idx_i] = bit_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pack_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pack_q <= pack_d;
      // The flushing bit is folded in directly so the byte is presented the next cycle.
      if (push_i && flush_i) begin
        data_q  <= pack_d;
        valid_q <= 1'b1;
      end else if (hs) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/neuron_bin_sched.sv
// Layer sequencer: streams activation/weight pairs per neuron into Neuron_bin, thresholds, packs results.
module neuron_bin_sched
  import neuron_bin_sched_pkg::*;
#(
  parameter int unsigned N_NEURONS = 64,
  parameter int unsigned IN_WORDS  = 98,
  parameter int unsigned AW_A      = 7,
  parameter int unsigned AW_W      = 13,
  parameter int unsigned AW_T      = 6
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [AW_A-1:0] act_addr,
  input  logic [7:0]      act_data,
  output logic [AW_W-1:0] w_addr,
  input  logic [7:0]      w_data,
  output logic [AW_T-1:0] t_addr,
  input  logic [31:0]     t_data,
  output logic [7:0]      nb_activ,
  output logic [7:0]      nb_weight,
  output logic            nb_in_valid,
  output logic [15:0]     nb_in_length,
  output logic [31:0]     nb_thr,
  output logic            nb_thr_valid,
  input  logic            nb_quant_ready,
  input  logic [7:0]      nb_out,
  input  logic            nb_out_valid,
  output logic [7:0]      o_data,
  output logic            o_valid,
  input  logic            o_ready
);

  localparam int unsigned    NW     = $clog2(N_NEURONS + 1);
  localparam logic [15:0]    IN16   = 16'(IN_WORDS);
  localparam logic [NW-1:0]  N_ALL  = NW'(N_NEURONS);
  localparam logic [NW-1:0]  N_LAST = NW'(N_NEURONS - 1);

  sched_state_e    state_q;
  logic [15:0]     k_q;
  logic [NW-1:0]   n_q;
  logic [2:0]      bit_q;
  logic [AW_W-1:0] w_ptr_q;
  logic            iss_q, rd_q, res_q;
  logic            busy_q, done_q;
  logic [AW_A-1:0] act_addr_q;
  logic [AW_W-1:0] w_addr_q;
  logic [AW_T-1:0] t_addr_q;
  logic [7:0]      nb_activ_q, nb_weight_q;
  logic            nb_in_valid_q;
  logic [15:0]     nb_in_length_q;
  logic [31:0]     nb_thr_q;
  logic            nb_thr_valid_q;

  logic hs, last_n, push, flush, enter_feed;

  always_comb begin
    hs         = o_valid && o_ready;
    last_n     = (n_q == N_LAST);
    push       = (state_q == S_COLLECT);
    flush      = push && ((bit_q == 3'd7) || last_n);
    enter_feed = ((state_q == S_IDLE) && start) ||
                 (push && !flush) ||
                 ((state_q == S_EMIT) && hs && (n_q != N_ALL));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= S_IDLE;
      k_q            <= '0;
      n_q            <= '0;
      bit_q          <= '0;
      w_ptr_q        <= '0;
      iss_q          <= 1'b0;
      rd_q           <= 1'b0;
      res_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      act_addr_q     <= '0;
      w_addr_q       <= '0;
      t_addr_q       <= '0;
      nb_activ_q     <= '0;
      nb_weight_q    <= '0;
      nb_in_valid_q  <= 1'b0;
      nb_in_length_q <= IN16;
      nb_thr_q       <= '0;
      nb_thr_valid_q <= 1'b0;
    end else begin
      rd_q          <= iss_q;
      nb_in_valid_q <= rd_q;
      nb_activ_q    <= rd_q ? act_data : '0;
      nb_weight_q   <= rd_q ? w_data : '0;
      t_addr_q      <= AW_T'(n_q);
      done_q        <= 1'b0;
      iss_q         <= 1'b0;

      // Word 0 is issued on the transition into FEED so the in_valid run has no leading gap.
      if (enter_feed) begin
        act_addr_q <= '0;
        w_addr_q   <= w_ptr_q;
        w_ptr_q    <= w_ptr_q + AW_W'(1);
        k_q        <= 16'd1;
        iss_q      <= 1'b1;
      end else if ((state_q == S_FEED) && (k_q != IN16)) begin
        act_addr_q <= AW_A'(k_q);
        w_addr_q   <= w_ptr_q;
        w_ptr_q    <= w_ptr_q + AW_W'(1);
        k_q        <= k_q + 16'd1;
        iss_q      <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            state_q <= S_FEED;
          end
        end
        S_FEED: begin
          if (k_q == IN16) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (nb_quant_ready && !iss_q && !rd_q && !nb_in_valid_q) begin
            nb_thr_q       <= t_data;
            nb_thr_valid_q <= 1'b1;
            state_q        <= S_QUANT;
          end
        end
        S_QUANT: begin
          if (nb_out_valid) begin
            res_q          <= nb_out[0];
            nb_thr_valid_q <= 1'b0;
            state_q        <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          n_q     <= n_q + NW'(1);
          bit_q   <= bit_q + 3'd1;
          state_q <= flush ? S_EMIT : S_FEED;
        end
        S_EMIT: begin
          if (hs) begin
            if (n_q == N_ALL) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              state_q <= S_FEED;
            end
          end
        end
        S_FIN: begin
          n_q     <= '0;
          bit_q   <= '0;
          k_q     <= '0;
          w_ptr_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  bit_packer8 u_packer (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .push_i  (push),
    .idx_i   (bit_q),
    .bit_i   (res_q),
    .flush_i (flush),
    .ready_i (o_ready),
    .data_o  (o_data),
    .valid_o (o_valid)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign act_addr     = act_addr_q;
  assign w_addr       = w_addr_q;
  assign t_addr       = t_addr_q;
  assign nb_activ     = nb_activ_q;
  assign nb_weight    = nb_weight_q;
  assign nb_in_valid  = nb_in_valid_q;
  assign nb_in_length = nb_in_length_q;
  assign nb_thr       = nb_thr_q;
  assign nb_thr_valid = nb_thr_valid_q;

endmodule

// File: tb/tb_neuron_bin_sched.sv
// Bench for neuron_bin_sched: memory models, a behavioural Neuron_bin stand-in and a layer-level reference.
module tb_neuron_bin_sched;

  localparam int N    = 10;
  localparam int IN   = 3;
  localparam int AW_A = 2;
  localparam int AW_W = 5;
  localparam int AW_T = 4;
  localparam int NB   = (N + 7) / 8;
  localparam int LAT  = 3;

  logic            sys_clk, sys_rst_n, start;
  logic            busy, done;
  logic [AW_A-1:0] act_addr;
  logic [7:0]      act_data;
  logic [AW_W-1:0] w_addr;
  logic [7:0]      w_data;
  logic [AW_T-1:0] t_addr;
  logic [31:0]     t_data;
  logic [7:0]      nb_activ, nb_weight;
  logic            nb_in_valid;
  logic [15:0]     nb_in_length;
  logic [31:0]     nb_thr;
  logic            nb_thr_valid;
  logic            nb_quant_ready;
  logic [7:0]      nb_out;
  logic            nb_out_valid;
  logic [7:0]      o_data;
  logic            o_valid, o_ready;

  neuron_bin_sched #(
    .N_NEURONS (N),
    .IN_WORDS  (IN),
    .AW_A      (AW_A),
    .AW_W      (AW_W),
    .AW_T      (AW_T)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .act_addr       (act_addr),
    .act_data       (act_data),
    .w_addr         (w_addr),
    .w_data         (w_data),
    .t_addr         (t_addr),
    .t_data         (t_data),
    .nb_activ       (nb_activ),
    .nb_weight      (nb_weight),
    .nb_in_valid    (nb_in_valid),
    .nb_in_length   (nb_in_length),
    .nb_thr         (nb_thr),
    .nb_thr_valid   (nb_thr_valid),
    .nb_quant_ready (nb_quant_ready),
    .nb_out         (nb_out),
    .nb_out_valid   (nb_out_valid),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .o_ready        (o_ready)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [7:0]  act_mem [0:3];
  logic [7:0]  w_mem   [0:31];
  logic [31:0] t_mem   [0:15];

  always @(posedge sys_clk) begin
    act_data <= act_mem[act_addr];
    w_data   <= w_mem[w_addr];
    t_data   <= t_mem[t_addr];
  end

  // Neuron_bin stand-in: XNOR-popcount accumulate, ready LAT cycles after the last word, sticky result.
  logic [15:0] dp_cnt;
  int          dp_acc;
  int          dp_cd;
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dp_cnt         <= '0;
      dp_acc         <= 0;
      dp_cd          <= 0;
      nb_quant_ready <= 1'b0;
      nb_out         <= '0;
      nb_out_valid   <= 1'b0;
    end else begin
      if (dp_cd > 0) begin
        dp_cd <= dp_cd - 1;
        if (dp_cd == 1) nb_quant_ready <= 1'b1;
      end
      if (nb_in_valid) begin
        dp_acc <= ((dp_cnt == 16'd0) ? 0 : dp_acc) + $countones(~(nb_activ ^ nb_weight));
        if (dp_cnt == 16'd0) begin
          nb_out_valid   <= 1'b0;
          nb_quant_ready <= 1'b0;
        end
        if (dp_cnt == 16'(IN - 1)) begin
          dp_cnt <= '0;
          dp_cd  <= LAT;
        end else begin
          dp_cnt <= dp_cnt + 16'd1;
        end
      end else begin
        dp_cnt <= '0;
      end
      if (nb_quant_ready && nb_thr_valid && !nb_out_valid) begin
        nb_out         <= {7'd0, (dp_acc >= $signed(nb_thr))};
        nb_out_valid   <= 1'b1;
        nb_quant_ready <= 1'b0;
      end
    end
  end

  logic [7:0] byte_log [$];
  logic [7:0] beat_a   [$];
  logic [7:0] beat_w   [$];
  int         run_log  [$];
  int         run_len;
  int         done_cnt;

  initial begin
    run_len  = 0;
    done_cnt = 0;
  end

  always @(negedge sys_clk) begin
    if (o_valid && o_ready) byte_log.push_back(o_data);
    if (nb_in_valid) begin
      beat_a.push_back(nb_activ);
      beat_w.push_back(nb_weight);
      run_len <= run_len + 1;
    end else if (run_len != 0) begin
      run_log.push_back(run_len);
      run_len <= 0;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int         n_tests, n_fail;
  int         b0, r0, q0, d0;
  logic [7:0] exp_b [0:NB-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_random();
    for (int k = 0; k < 4; k++)  act_mem[k] = 8'($urandom);
    for (int i = 0; i < 32; i++) w_mem[i]   = 8'($urandom);
    for (int n = 0; n < 16; n++) t_mem[n]   = 32'($urandom_range(8, 16));
  endtask

  task automatic load_pattern();
    for (int k = 0; k < 4; k++)  act_mem[k] = 8'hFF;
    for (int i = 0; i < 32; i++) w_mem[i]   = ((i / IN) % 2 == 0) ? 8'hFF : 8'h00;
    for (int n = 0; n < 16; n++) t_mem[n]   = 32'd12;
  endtask

  // Reference: neuron n fires when sum_k popcount(~(act[k]^w[n*IN+k])) >= signed thr[n].
  task automatic calc_expected();
    int s;
    for (int b = 0; b < NB; b++) exp_b[b] = 8'h00;
    for (int n = 0; n < N; n++) begin
      s = 0;
      for (int k = 0; k < IN; k++) s += $countones(~(act_mem[k] ^ w_mem[n * IN + k]));
      if (s >= $signed(t_mem[n])) exp_b[n / 8][n % 8] = 1'b1;
    end
  endtask

  task automatic snapshot();
    b0 = byte_log.size();
    r0 = run_log.size();
    q0 = beat_a.size();
    d0 = done_cnt;
  endtask

  task automatic pulse_start();
    @(posedge sys_clk);
    #1 start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input bit pulse_on_done);
    int seen;
    seen = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge sys_clk);
      if (done) begin
        seen = 1;
        if (pulse_on_done) start = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (pulse_on_done) begin
      @(posedge sys_clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic check_layer(input string tag);
    int bad;
    @(negedge sys_clk);
    calc_expected();
    chk({tag, "/byte_count"}, 64'(byte_log.size() - b0), 64'(NB));
    for (int i = 0; i < NB; i++)
      if (b0 + i < byte_log.size())
        chk($sformatf("%s/byte%0d", tag, i), 64'(byte_log[b0 + i]), 64'(exp_b[i]));
    chk({tag, "/run_count"}, 64'(run_log.size() - r0), 64'(N));
    bad = 0;
    for (int i = r0; i < run_log.size(); i++) if (run_log[i] != IN) bad++;
    chk({tag, "/run_lengths"}, 64'(bad), 64'd0);
    chk({tag, "/beat_count"}, 64'(beat_a.size() - q0), 64'(N * IN));
    bad = 0;
    for (int j = 0; j < N * IN; j++)
      if (q0 + j < beat_a.size())
        if (beat_a[q0 + j] !== act_mem[j % IN] || beat_w[q0 + j] !== w_mem[j]) bad++;
    chk({tag, "/beat_data"}, 64'(bad), 64'd0);
    chk({tag, "/done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "/busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int         seen, ok;
    logic [7:0] hold_d;
    logic [AW_W-1:0] hold_w;
    n_tests   = 0;
    n_fail    = 0;
    start     = 1'b0;
    o_ready   = 1'b1;
    sys_rst_n = 1'b0;
    load_random();

    repeat (3) @(negedge sys_clk);
    chk("rst_ctl", 64'({busy, done, nb_in_valid, nb_thr_valid, o_valid, act_addr, w_addr, t_addr}), 64'd0);
    chk("rst_data", 64'({nb_activ, nb_weight, o_data}), 64'd0);
    chk("rst_thr", 64'(nb_thr), 64'd0);
    chk("rst_in_length", 64'(nb_in_length), 64'(IN));
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Random layer, downstream always ready.
    load_random();
    snapshot();
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done(1'b0);
    check_layer("rand1");

    // All-match / all-mismatch alternating neurons.
    load_pattern();
    snapshot();
    pulse_start();
    wait_done(1'b0);
    check_layer("pattern");
    chk("pattern/b0_55", 64'(byte_log[b0]), 64'h55);
    chk("pattern/b1_01", 64'(byte_log[b0 + 1]), 64'h01);

    // Stall the first byte; re-pulse start while busy and again coincident with done.
    load_random();
    o_ready = 1'b0;
    snapshot();
    pulse_start();
    seen = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge sys_clk);
      if (o_valid) begin
        seen = 1;
        break;
      end
    end
    chk("stall/first_byte_seen", 64'(seen), 64'd1);
    hold_d = o_data;
    hold_w = w_addr;
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (i == 5) start = 1'b1;
      if (i == 6) start = 1'b0;
      if (!(o_valid === 1'b1 && o_data === hold_d && nb_in_valid === 1'b0 && w_addr === hold_w)) ok = 0;
    end
    chk("stall/hold_and_no_feed", 64'(ok), 64'd1);
    o_ready = 1'b1;
    wait_done(1'b1);
    check_layer("stall");
    ok = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      if (busy !== 1'b0 || nb_in_valid !== 1'b0) ok = 0;
    end
    chk("start_at_done_ignored", 64'(ok), 64'd1);

    // Abort mid-FEED of neuron 3, then a full layer must come out clean.
    load_random();
    pulse_start();
    seen = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge sys_clk);
      if (w_addr == AW_W'(3 * IN)) begin
        seen = 1;
        break;
      end
    end
    chk("abort/reached_neuron3", 64'(seen), 64'd1);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("abort/ctl_zero", 64'({busy, done, nb_in_valid, nb_thr_valid, o_valid, act_addr, w_addr, t_addr}), 64'd0);
    chk("abort/data_zero", 64'({nb_activ, nb_weight, o_data}), 64'd0);
    chk("abort/thr_zero", 64'(nb_thr), 64'd0);
    chk("abort/in_length", 64'(nb_in_length), 64'(IN));
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    load_random();
    snapshot();
    pulse_start();
    wait_done(1'b0);
    check_layer("after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
